// File: rtl/serial_subtractor_pkg.sv
//----------------------------------------------------------------------------
// Module : serial_subtractor_pkg
// Brief  : Shared FSM state encodings, mode constants and overflow helper
//          for the bit-serial arithmetic units.
// Rev    : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sub_state_t;

  localparam logic C_MODE_UNSIGNED = 1'b0;
  localparam logic C_MODE_SIGNED   = 1'b1;

  // Two's-complement overflow of a - b: operand signs differ and the
  // difference sign departs from the minuend sign.
  function automatic logic signed_sub_overflow(input logic a_msb,
                                               input logic b_msb,
                                               input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

endpackage

`default_nettype wire

// File: rtl/full_subtractor_bit.sv
//----------------------------------------------------------------------------
// Module : full_subtractor_bit
// Brief  : Combinational 1-bit full subtractor cell (a - b - bin).
// Rev    : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

module full_subtractor_bit (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_d,
  output logic o_bout
);

  assign o_d    = i_a ^ i_b ^ i_bin;
  assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
//----------------------------------------------------------------------------
// Module : serial_subtractor
// Brief  : Bit-serial WIDTH-bit subtractor, LSB first, with unsigned borrow
//          or signed overflow flagging and a start/done handshake.
// Rev    : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic             mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  localparam int             CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);

  sub_state_t       r_state;
  sub_state_t       w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic [CW-1:0]    r_count;
  logic             r_borrow;
  logic             r_mode;
  logic             r_overflow;
  logic             w_d;
  logic             w_bout;
  logic             w_accept;
  logic             w_last;

  full_subtractor_bit u_cell (
    .i_a    (r_a[0]),
    .i_b    (r_b[0]),
    .i_bin  (r_borrow),
    .o_d    (w_d),
    .o_bout (w_bout)
  );

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = (r_state == ST_RUN) && (r_count == C_LAST);
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        // A start here chains straight into the next operation.
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = ST_RUN;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_a        <= '0;
      r_b        <= '0;
      r_result   <= '0;
      r_count    <= '0;
      r_borrow   <= 1'b0;
      r_mode     <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_accept) begin
      r_a      <= operand1;
      r_b      <= operand2;
      r_mode   <= mode;
      r_borrow <= 1'b0;
      r_count  <= '0;
    end else if (r_state == ST_RUN) begin
      r_a      <= r_a >> 1;
      r_b      <= r_b >> 1;
      r_borrow <= w_bout;
      r_result <= {w_d, r_result[WIDTH-1:1]};
      r_count  <= r_count + CW'(1);
      // On the last bit r_a[0]/r_b[0] hold the operand sign bits.
      if (w_last) begin
        r_overflow <= (r_mode == C_MODE_SIGNED)
                      ? signed_sub_overflow(r_a[0], r_b[0], w_d)
                      : w_bout;
      end
    end
  end

  assign busy     = (r_state == ST_RUN);
  assign done     = (r_state == ST_DONE);
  assign result   = r_result;
  assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
//----------------------------------------------------------------------------
// Module : tb_serial_subtractor
// Brief  : Self-checking bench for serial_subtractor at WIDTH=3 and WIDTH=8.
// Rev    : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_serial_subtractor;

  logic       clock = 1'b0;
  logic       reset;
  logic       start3, mode3, busy3, done3, ovf3;
  logic [2:0] op1_3, op2_3, result3;
  logic       start8, mode8, busy8, done8, ovf8;
  logic [7:0] op1_8, op2_8, result8;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  serial_subtractor #(.WIDTH(3)) u_dut3 (
    .clock(clock), .reset(reset), .start(start3), .operand1(op1_3),
    .operand2(op2_3), .mode(mode3), .busy(busy3), .done(done3),
    .result(result3), .overflow(ovf3)
  );

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clock(clock), .reset(reset), .start(start8), .operand1(op1_8),
    .operand2(op2_8), .mode(mode8), .busy(busy8), .done(done8),
    .result(result8), .overflow(ovf8)
  );

  // Reference: plain integer arithmetic on the operand values.
  function automatic void ref_sub(input int w, input int a, input int b,
                                  input logic m, output int r, output logic ov);
    int modv, sa, sb, diff;
    modv = 1 << w;
    r    = ((a - b) % modv + modv) % modv;
    if (!m) begin
      ov = (a < b);
    end else begin
      sa   = (a >= modv / 2) ? a - modv : a;
      sb   = (b >= modv / 2) ? b - modv : b;
      diff = sa - sb;
      ov   = (diff < -(modv / 2)) || (diff > modv / 2 - 1);
    end
  endfunction

  task automatic run3(input logic [2:0] a, input logic [2:0] b, input logic m);
    int   r, lat;
    logic ov;
    ref_sub(3, int'(a), int'(b), m, r, ov);
    start3 = 1'b1; op1_3 = a; op2_3 = b; mode3 = m;
    @(posedge clock); #1;
    start3 = 1'b0; op1_3 = 3'($urandom); op2_3 = 3'($urandom); mode3 = ~m;
    lat = 1;
    checks++;
    if (busy3 !== 1'b1) begin errors++; $display("FAIL busy3_after_start: got %b want 1", busy3); end
    while (done3 !== 1'b1 && lat < 20) begin @(posedge clock); #1; lat++; end
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL latency3 %0d-%0d m%0d: got %0d want 4", a, b, m, lat); end
    checks++;
    if (result3 !== 3'(r)) begin errors++; $display("FAIL result3 %0d-%0d m%0d: got %0d want %0d", a, b, m, result3, r); end
    checks++;
    if (ovf3 !== ov) begin errors++; $display("FAIL overflow3 %0d-%0d m%0d: got %b want %b", a, b, m, ovf3, ov); end
    @(posedge clock); #1;
    checks++;
    if (done3 !== 1'b0 || busy3 !== 1'b0) begin errors++; $display("FAIL idle3_after_done: got done=%b busy=%b want 0 0", done3, busy3); end
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic m);
    int   r, lat;
    logic ov;
    ref_sub(8, int'(a), int'(b), m, r, ov);
    start8 = 1'b1; op1_8 = a; op2_8 = b; mode8 = m;
    @(posedge clock); #1;
    start8 = 1'b0; op1_8 = 8'($urandom); op2_8 = 8'($urandom); mode8 = ~m;
    lat = 1;
    while (done8 !== 1'b1 && lat < 40) begin @(posedge clock); #1; lat++; end
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL latency8 %0d-%0d m%0d: got %0d want 9", a, b, m, lat); end
    checks++;
    if (result8 !== 8'(r) || ovf8 !== ov) begin
      errors++;
      $display("FAIL sub8 %0d-%0d m%0d: got r=%0d ov=%b want r=%0d ov=%b", a, b, m, result8, ovf8, r, ov);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start3 = 0; op1_3 = 0; op2_3 = 0; mode3 = 0;
    start8 = 0; op1_8 = 0; op2_8 = 0; mode8 = 0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({busy3, done3, result3, ovf3} !== 6'b0) begin errors++; $display("FAIL reset3: got %b want 000000", {busy3, done3, result3, ovf3}); end
    checks++;
    if ({busy8, done8, result8, ovf8} !== 11'b0) begin errors++; $display("FAIL reset8: got %b want 0", {busy8, done8, result8, ovf8}); end
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_directed();
    run3(3'b101, 3'b011, 1'b0);
    run3(3'b010, 3'b101, 1'b0);
    run3(3'b011, 3'b100, 1'b1);
    run3(3'b010, 3'b011, 1'b1);
    run3(3'b100, 3'b001, 1'b1);
  endtask

  task automatic test_random3();
    for (int i = 0; i < 60; i++) run3(3'($urandom), 3'($urandom), 1'($urandom));
  endtask

  task automatic test_start_ignored();
    int   r, lat;
    logic ov;
    ref_sub(3, 6, 1, 1'b0, r, ov);
    start3 = 1'b1; op1_3 = 3'd6; op2_3 = 3'd1; mode3 = 1'b0;
    @(posedge clock); #1;
    start3 = 1'b0; lat = 1;
    @(posedge clock); #1; lat++;
    start3 = 1'b1; op1_3 = 3'd1; op2_3 = 3'd6; mode3 = 1'b1;
    @(posedge clock); #1; lat++;
    start3 = 1'b0;
    while (done3 !== 1'b1 && lat < 20) begin @(posedge clock); #1; lat++; end
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL ignore_latency: got %0d want 4", lat); end
    checks++;
    if (result3 !== 3'(r) || ovf3 !== ov) begin errors++; $display("FAIL ignore_result: got r=%0d ov=%b want r=%0d ov=%b", result3, ovf3, r, ov); end
    @(posedge clock); #1;
    checks++;
    if (busy3 !== 1'b0 || done3 !== 1'b0) begin errors++; $display("FAIL ignore_idle: got busy=%b done=%b want 0 0", busy3, done3); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] qa[4];
    logic [2:0] qb[4];
    logic       qm[4];
    int         r, lat;
    logic       ov;
    for (int i = 0; i < 4; i++) begin qa[i] = 3'($urandom); qb[i] = 3'($urandom); qm[i] = 1'($urandom); end
    start3 = 1'b1; op1_3 = qa[0]; op2_3 = qb[0]; mode3 = qm[0];
    for (int k = 0; k < 4; k++) begin
      lat = 0;
      do begin @(posedge clock); #1; lat++; end while (done3 !== 1'b1 && lat < 20);
      ref_sub(3, int'(qa[k]), int'(qb[k]), qm[k], r, ov);
      checks++;
      if (lat !== 4) begin errors++; $display("FAIL b2b_period op%0d: got %0d want 4", k, lat); end
      checks++;
      if (result3 !== 3'(r) || ovf3 !== ov) begin errors++; $display("FAIL b2b_result op%0d: got r=%0d ov=%b want r=%0d ov=%b", k, result3, ovf3, r, ov); end
      if (k < 3) begin op1_3 = qa[k+1]; op2_3 = qb[k+1]; mode3 = qm[k+1]; end
      else start3 = 1'b0;
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset_mid_run();
    int seen;
    start3 = 1'b1; op1_3 = 3'b101; op2_3 = 3'b011; mode3 = 1'b0;
    @(posedge clock); #1;
    start3 = 1'b0;
    repeat (2) begin @(posedge clock); #1; end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy3, done3, result3, ovf3} !== 6'b0) begin errors++; $display("FAIL reset_mid_run: got %b want 000000", {busy3, done3, result3, ovf3}); end
    @(posedge clock); #1;
    reset = 1'b0;
    seen = 0;
    repeat (6) begin @(posedge clock); #1; if (done3 === 1'b1) seen++; end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL no_done_after_reset: got %0d pulses want 0", seen); end
    run3(3'b111, 3'b111, 1'b0);
  endtask

  task automatic test_width8();
    run8(8'd0, 8'd0, 1'b0);
    run8(8'd0, 8'd255, 1'b0);
    run8(8'd255, 8'd0, 1'b0);
    run8(8'd128, 8'd1, 1'b1);
    run8(8'd127, 8'd255, 1'b1);
    run8(8'd128, 8'd128, 1'b1);
    for (int i = 0; i < 1500; i++) run8(8'($urandom), 8'($urandom), 1'($urandom));
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random3();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
    test_width8();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
